regfile_mp: RTL
===============

# regfile_mp

Parametrised multi-port register file for the core datapath. It replaces the single-write, dual-read register file and adds:
- configurable width, depth and port counts;
- same-cycle write-to-read bypass;
- deterministic resolution when several write ports hit the same register;
- a per-register pending scoreboard, so decode can detect read-after-write hazards on in-flight results.

It sits between decode (reads and claims) and writeback (writes).

## Interface
Parameters:
- XLEN, 32, data width in bits (≥ 8)
- NREG, 32, number of registers (power of two, 2..64)
- NRD, 2, read ports (1..4)
- NWR, 1, write ports (1..2)
- AW, derived, $clog2(NREG); not user-set

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-low: asserted when 0, deasserted synchronously to clk by the system
- rd_en  in  NRD  per-port read enable
- rd_sel  in  NRD*AW  read addresses; port p uses bits [p*AW +: AW]
- rd_data  out  NRD*XLEN  registered read data; port p uses bits [p*XLEN +: XLEN]
- rd_busy  out  NRD  registered pending flag of the register read on each port
- wr_en  in  NWR  per-port write enable
- wr_sel  in  NWR*AW  write addresses
- wr_data  in  NWR*XLEN  write data
- claim_en  in  1  mark a destination register as pending
- claim_sel  in  AW  register to mark

## Operation
Reset, while rst = 0, immediately:
- reg[i] = i, truncated to XLEN;
- all pending bits = 0;
- rd_data = 0 on every port;
- rd_busy = 0 on every port.

Write:
- On each edge where wr_en[w] = 1, reg[wr_sel[w]] <= wr_data[w], and the pending bit of that register is cleared.
- If two write ports target the same register, the higher-indexed port wins.

Read:
- On an edge where rd_en[p] = 1, rd_data[p] <= the effective value of reg[rd_sel[p]].
- rd_busy[p] <= the effective pending state of that register.
- When rd_en[p] = 0, rd_data[p] and rd_busy[p] hold their previous values.

Bypass:
- The effective value is the highest-indexed same-cycle write data whose wr_sel matches rd_sel; otherwise it is the stored value.
- The effective pending state is 0 if any same-cycle write matches; otherwise it is the stored pending bit.
- Same-cycle claims are not bypassed to reads.

Claim:
- On an edge where claim_en = 1, the pending bit of claim_sel is set.
- If a write and a claim hit the same register in the same cycle, the data is written and the pending bit ends up set. The claim wins because it is a newer producer.

Addresses are always in range, since NREG = 2^AW. There is no error path.

## Timing
- Read latency: 1 cycle. Address presented at edge N → data valid after edge N. The reg state seen at edge N already includes writes issued at edge N.
- Write-visible latency via storage: a read issued one cycle after the write returns the written data without bypass.
- Claim to rd_busy: a claim at edge N is seen by a read at edge N+1 or later.
- Reset mid-operation: all state is forced to its reset values asynchronously. The first edge after release behaves as a fresh cycle.
- No combinational path from any input to rd_data or rd_busy.

## Configuration
- REGFILE_ZERO_REG_EN defined:
  - reg[0] is hardwired to 0 and resets to 0;
  - writes to address 0 are discarded and never bypassed, so reads of address 0 always return 0 with rd_busy = 0;
  - claims to address 0 are ignored.
- REGFILE_ZERO_REG_EN undefined: register 0 is an ordinary register that resets to 0 and is writable and claimable.

## Test plan
- Reset, default parameters: pulse rst low mid-cycle, then read addresses 5 and 31 → rd_data = 5 and 31, rd_busy = 0. Outputs read 0 during reset.
- Bypass: wr_en = 1, wr_sel = 7, wr_data = 0xDEADBEEF, with rd_sel[0] = 7 on the same edge → rd_data[0] = 0xDEADBEEF one cycle later.
- Write collision, NWR = 2: both ports write register 3 with 0x11 and 0x22 → the next read returns 0x22.
- Scoreboard:
  - claim register 9, then read it → rd_busy = 1;
  - write register 9 while reading it on the same edge → rd_busy = 0 and data bypassed;
  - claim and write register 9 on the same edge → a later read gives rd_busy = 1 with the written data.
- Zero register:
  - REGFILE_ZERO_REG_EN defined: write 0x55 to register 0 and read it on the same edge and the next → both reads return 0, rd_busy = 0.
  - REGFILE_ZERO_REG_EN undefined: the same stimulus returns 0x55 on both reads.
- Hold: rd_en = 0 while the selected register is rewritten → rd_data is unchanged.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file with same-cycle write bypass and a per-register pending scoreboard.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero (writes and claims to it are dropped).
module regfile_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 1,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD-1:0]      rd_en,
  input  logic [NRD*AW-1:0]   rd_sel,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_sel,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                claim_en,
  input  logic [AW-1:0]       claim_sel
);

  logic [XLEN-1:0]     r_regs [NREG];
  logic [NREG-1:0]     r_pend;
  logic [NRD*XLEN-1:0] r_rd_data;
  logic [NRD-1:0]      r_rd_busy;

  logic [NWR-1:0]      w_wr_ok;
  logic                w_claim_ok;
  logic [XLEN-1:0]     w_eff_data [NRD];
  logic [NRD-1:0]      w_eff_busy;

  // Qualified writes/claims: with the zero register enabled, address 0 is inert.
  always_comb begin
    for (int w = 0; w < NWR; w++) begin
`ifdef REGFILE_ZERO_REG_EN
      w_wr_ok[w] = wr_en[w] && (wr_sel[w*AW +: AW] != '0);
`else
      w_wr_ok[w] = wr_en[w];
`endif
    end
`ifdef REGFILE_ZERO_REG_EN
    w_claim_ok = claim_en && (claim_sel != '0);
`else
    w_claim_ok = claim_en;
`endif
  end

  // NOTE: the array is built from flops with an async reset so every entry
  // takes its index value at reset; a RAM macro could not be initialised this way.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= XLEN'(i);
      end
      r_pend <= '0;
    end else begin
      // NOTE: non-blocking updates in port order; the last one scheduled wins,
      // giving the higher write port priority and the claim priority over any write.
      for (int w = 0; w < NWR; w++) begin
        if (w_wr_ok[w]) begin
          r_regs[wr_sel[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
          r_pend[wr_sel[w*AW +: AW]] <= 1'b0;
        end
      end
      if (w_claim_ok) begin
        r_pend[claim_sel] <= 1'b1;
      end
    end
  end

  // Effective read state: stored value, overridden by the highest matching write.
  always_comb begin
    for (int p = 0; p < NRD; p++) begin
      // NOTE: defaults first so no path through the loop leaves a value unassigned.
      w_eff_data[p] = r_regs[rd_sel[p*AW +: AW]];
      w_eff_busy[p] = r_pend[rd_sel[p*AW +: AW]];
      for (int w = 0; w < NWR; w++) begin
        if (w_wr_ok[w] && (wr_sel[w*AW +: AW] == rd_sel[p*AW +: AW])) begin
          w_eff_data[p] = wr_data[w*XLEN +: XLEN];
          w_eff_busy[p] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_data <= '0;
      r_rd_busy <= '0;
    end else begin
      for (int p = 0; p < NRD; p++) begin
        if (rd_en[p]) begin
          r_rd_data[p*XLEN +: XLEN] <= w_eff_data[p];
          r_rd_busy[p]              <= w_eff_busy[p];
        end
      end
    end
  end

  assign rd_data = r_rd_data;
  assign rd_busy = r_rd_busy;

endmodule
